// File: rtl/proc_hazard_ctrl_pkg.sv
// Shared TinyRV1 hazard-control types: the per-stage writeback entry kept after D,
// bypass/ready-stage constants and the register-match helper.
package proc_hazard_ctrl_pkg;

    localparam int unsigned HZ_AW_MAX = 8;
    localparam int unsigned HZ_SW_MAX = 4;

    localparam logic [HZ_SW_MAX-1:0] BYP_RF = 4'd0;
    localparam logic [HZ_SW_MAX-1:0] RDY_X  = 4'd1;
    localparam logic [HZ_SW_MAX-1:0] RDY_M  = 4'd2;

    typedef struct packed {
        logic                 val;
        logic                 wen;
        logic [HZ_AW_MAX-1:0] rd;
        logic [HZ_SW_MAX-1:0] rdy;
    } hz_entry_t;

    localparam hz_entry_t HZ_BUBBLE = '{1'b0, 1'b0, 8'd0, 4'd0};

    // x0 is hard-wired zero, so a write to it never produces a dependency
    function automatic logic hz_match(input hz_entry_t e, input logic [HZ_AW_MAX-1:0] s);
        return e.val & e.wen & (e.rd == s) & (s != 8'd0);
    endfunction

endpackage

// File: rtl/proc_hazard_ctrl_reg.sv
// Generic enabled register with synchronous active-high reset; reset beats enable.
module proc_hazard_ctrl_reg #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // state register: clear on reset, otherwise load when enabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= {W{1'b0}};
        end else if (i_en) begin
            o_q <= i_d;
        end else begin
            o_q <= o_q;
        end
    end

endmodule

// File: rtl/proc_hazard_ctrl.sv
// Hazard controller for an in-order TinyRV1 pipeline with NSTAGES stages after D:
// bypass selects, RAW stalls, control-flow squashes and a whole-pipeline freeze.
module proc_hazard_ctrl
    import proc_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGES = 3,
    parameter int AW      = 5,
    parameter int SW      = $clog2(NSTAGES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          val_D,
    input  logic          rs1_en_D,
    input  logic          rs2_en_D,
    input  logic [AW-1:0] rs1_D,
    input  logic [AW-1:0] rs2_D,
    input  logic          wen_D,
    input  logic [AW-1:0] rd_D,
    input  logic [SW-1:0] rdy_D,
    input  logic          jump_D,
    input  logic          redirect_X,
    input  logic          freeze,
    output logic          stall_F,
    output logic          stall_D,
    output logic          squash_F,
    output logic          squash_D,
    output logic [SW-1:0] op1_byp_sel_D,
    output logic [SW-1:0] op2_byp_sel_D,
    output logic          val_X,
    output logic          rf_wen_W,
    output logic [AW-1:0] rf_waddr_W
);

    hz_entry_t [NSTAGES:1] w_ent_q;
    hz_entry_t             w_ent1_d;
    logic                  w_adv;
    logic [NSTAGES:1]      w_m1;
    logic [NSTAGES:1]      w_m2;
    logic [NSTAGES:1]      w_ok;
    logic [SW-1:0]         w_sel1;
    logic [SW-1:0]         w_sel2;
    logic                  w_stl1;
    logic                  w_stl2;
    logic                  w_squash_D;
    logic                  w_stall_D;

    assign w_adv = ~freeze;

    for (genvar k = 1; k <= NSTAGES; k++) begin : g_ent
        if (k == 1) begin : g_head
            proc_hazard_ctrl_reg #(.W($bits(hz_entry_t))) u_reg (
                .i_clk (clk),
                .i_rst (rst),
                .i_en  (w_adv),
                .i_d   (w_ent1_d),
                .o_q   (w_ent_q[k])
            );
        end else begin : g_tail
            proc_hazard_ctrl_reg #(.W($bits(hz_entry_t))) u_reg (
                .i_clk (clk),
                .i_rst (rst),
                .i_en  (w_adv),
                .i_d   (w_ent_q[k-1]),
                .o_q   (w_ent_q[k])
            );
        end

        assign w_m1[k] = val_D & rs1_en_D & hz_match(w_ent_q[k], HZ_AW_MAX'(rs1_D));
        assign w_m2[k] = val_D & rs2_en_D & hz_match(w_ent_q[k], HZ_AW_MAX'(rs2_D));
        assign w_ok[k] = (HZ_SW_MAX'(k) >= w_ent_q[k].rdy);
    end

    // priority search: walk oldest to youngest so the youngest match lands last
    always_comb begin
        w_sel1 = SW'(BYP_RF);
        w_sel2 = SW'(BYP_RF);
        w_stl1 = 1'b0;
        w_stl2 = 1'b0;
        for (int k = NSTAGES; k >= 1; k--) begin
            w_sel1 = w_m1[k] ? (w_ok[k] ? SW'(k) : SW'(BYP_RF)) : w_sel1;
            w_stl1 = w_m1[k] ? ~w_ok[k] : w_stl1;
            w_sel2 = w_m2[k] ? (w_ok[k] ? SW'(k) : SW'(BYP_RF)) : w_sel2;
            w_stl2 = w_m2[k] ? ~w_ok[k] : w_stl2;
        end
    end

    assign w_squash_D = redirect_X & ~freeze;
    assign w_stall_D  = freeze | (val_D & (w_stl1 | w_stl2) & ~w_squash_D);

    // X entry: D metadata when it actually issues, otherwise a bubble
    always_comb begin
        w_ent1_d = HZ_BUBBLE;
        if (val_D & ~w_stall_D & ~w_squash_D) begin
            w_ent1_d = '{1'b1, wen_D, HZ_AW_MAX'(rd_D), HZ_SW_MAX'(rdy_D)};
        end else begin
            w_ent1_d = HZ_BUBBLE;
        end
    end

    assign stall_D       = w_stall_D;
    assign stall_F       = w_stall_D;
    assign squash_D      = w_squash_D;
    assign squash_F      = w_squash_D | (val_D & jump_D & ~w_stall_D & ~freeze);
    assign op1_byp_sel_D = w_sel1;
    assign op2_byp_sel_D = w_sel2;
    assign val_X         = w_ent_q[1].val;
    assign rf_wen_W      = w_ent_q[NSTAGES].val & w_ent_q[NSTAGES].wen & ~freeze;
    assign rf_waddr_W    = w_ent_q[NSTAGES].rd[AW-1:0];

endmodule

// File: tb/tb_proc_hazard_ctrl.sv
// Self-checking bench for proc_hazard_ctrl: directed vector table, multi-cycle corner
// sequences (freeze, reset, 5-stage long-latency stall) and a randomized model comparison.
module tb_proc_hazard_ctrl;

    localparam int N   = 3;
    localparam int AW  = 5;
    localparam int SW  = 2;
    localparam int N5  = 5;
    localparam int SW5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, val_D, rs1_en_D, rs2_en_D, wen_D, jump_D, redirect_X, freeze;
    logic [AW-1:0] rs1_D, rs2_D, rd_D;
    logic [SW-1:0] rdy_D;
    logic [SW5-1:0] rdy5_D;

    logic          stall_F, stall_D, squash_F, squash_D, val_X, rf_wen_W;
    logic [SW-1:0] op1_sel, op2_sel;
    logic [AW-1:0] rf_waddr_W;

    logic           stall_F5, stall_D5, squash_F5, squash_D5, val_X5, rf_wen_W5;
    logic [SW5-1:0] op1_sel5, op2_sel5;
    logic [AW-1:0]  rf_waddr_W5;

    proc_hazard_ctrl #(.NSTAGES(N), .AW(AW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .val_D(val_D), .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .wen_D(wen_D), .rd_D(rd_D), .rdy_D(rdy_D),
        .jump_D(jump_D), .redirect_X(redirect_X), .freeze(freeze),
        .stall_F(stall_F), .stall_D(stall_D), .squash_F(squash_F), .squash_D(squash_D),
        .op1_byp_sel_D(op1_sel), .op2_byp_sel_D(op2_sel), .val_X(val_X),
        .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W)
    );

    proc_hazard_ctrl #(.NSTAGES(N5), .AW(AW), .SW(SW5)) dut5 (
        .clk(clk), .rst(rst), .val_D(val_D), .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .wen_D(wen_D), .rd_D(rd_D), .rdy_D(rdy5_D),
        .jump_D(jump_D), .redirect_X(redirect_X), .freeze(freeze),
        .stall_F(stall_F5), .stall_D(stall_D5), .squash_F(squash_F5), .squash_D(squash_D5),
        .op1_byp_sel_D(op1_sel5), .op2_byp_sel_D(op2_sel5), .val_X(val_X5),
        .rf_wen_W(rf_wen_W5), .rf_waddr_W(rf_waddr_W5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: in-flight instructions, index 0 = X ----------------
    typedef struct { bit val; bit wen; int rd; int rdy; } ment_t;
    ment_t mq[$];
    int e_sel1, e_sel2, e_wa;
    bit e_stall, e_sqF, e_sqD, e_valx, e_rfw;

    function automatic void model_clear();
        ment_t b = '{0, 0, 0, 0};
        mq.delete();
        for (int i = 0; i < N; i++) mq.push_back(b);
    endfunction

    function automatic void lookup(input bit en, input int s, output int sel, output bit stl);
        sel = 0;
        stl = 0;
        if (val_D && en && s != 0) begin
            for (int i = 0; i < N; i++) begin
                if (mq[i].val && mq[i].wen && mq[i].rd == s) begin
                    if (i + 1 >= mq[i].rdy) sel = i + 1;
                    else stl = 1;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_eval();
        bit s1, s2;
        lookup(rs1_en_D, int'(rs1_D), e_sel1, s1);
        lookup(rs2_en_D, int'(rs2_D), e_sel2, s2);
        e_sqD   = redirect_X && !freeze;
        e_stall = freeze ? 1'b1 : (val_D && (s1 || s2) && !e_sqD);
        e_sqF   = e_sqD || (val_D && jump_D && !e_stall && !freeze);
        e_valx  = mq[0].val;
        e_rfw   = mq[N-1].val && mq[N-1].wen && !freeze;
        e_wa    = mq[N-1].rd;
    endfunction

    function automatic void model_step();
        ment_t nw = '{0, 0, 0, 0};
        model_eval();
        if (rst) begin
            model_clear();
        end else if (!freeze) begin
            if (val_D && !e_stall && !e_sqD) nw = '{1, wen_D, int'(rd_D), int'(rdy_D)};
            void'(mq.pop_back());
            mq.push_front(nw);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        model_eval();
        chk({tag, "_stallD"}, stall_D, e_stall);
        chk({tag, "_stallF"}, stall_F, e_stall);
        chk({tag, "_sqD"}, squash_D, e_sqD);
        chk({tag, "_sqF"}, squash_F, e_sqF);
        chk({tag, "_sel1"}, op1_sel, e_sel1);
        chk({tag, "_sel2"}, op2_sel, e_sel2);
        chk({tag, "_valX"}, val_X, e_valx);
        chk({tag, "_rfwen"}, rf_wen_W, e_rfw);
        chk({tag, "_waddr"}, rf_waddr_W, e_wa);
    endtask

    task automatic drive(input int v, r1e, r1, r2e, r2, w, rd, rdy, j, rx, fz);
        val_D = v[0]; rs1_en_D = r1e[0]; rs1_D = r1[4:0]; rs2_en_D = r2e[0]; rs2_D = r2[4:0];
        wen_D = w[0]; rd_D = rd[4:0]; rdy_D = rdy[1:0]; rdy5_D = rdy[2:0];
        jump_D = j[0]; redirect_X = rx[0]; freeze = fz[0];
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int val, r1e, r1, r2e, r2, wen, rd, rdy, jmp, rx, fz;
        int stall, sqF, sqD, s1, s2, valx, rfw, wa;
    } vec_t;
    vec_t tbl[19];

    int stalls, sel_after;
    bit done;

    initial begin
        tbl[0]  = '{1,0,0,0,0,1,1,1,0,0,0, 0,0,0,0,0,0,0,0};  // ADD x1
        tbl[1]  = '{1,1,1,1,3,1,2,1,0,0,0, 0,0,0,1,0,1,0,0};  // ADD x2,x1,x3
        tbl[2]  = '{1,1,2,0,0,1,4,2,0,0,0, 0,0,0,1,0,1,0,0};  // LW x4,(x2)
        tbl[3]  = '{1,1,4,1,4,1,5,1,0,0,0, 1,0,0,0,0,1,1,1};  // load-use stall
        tbl[4]  = '{1,1,4,1,4,1,5,1,0,0,0, 0,0,0,2,2,0,1,2};  // then sel=2
        tbl[5]  = '{1,1,4,1,5,1,6,1,0,0,0, 0,0,0,3,1,1,1,4};  // W bypass sel=3
        tbl[6]  = '{1,0,0,0,0,1,1,1,1,0,0, 0,1,0,0,0,1,0,0};  // JAL
        tbl[7]  = '{1,1,6,1,1,1,0,2,0,0,0, 0,0,0,2,1,1,1,5};  // writes x0
        tbl[8]  = '{1,1,0,1,0,0,0,1,0,0,0, 0,0,0,0,0,1,1,6};  // reads x0
        tbl[9]  = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,1,1};
        tbl[10] = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0};  // x0 write still enabled
        tbl[11] = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        tbl[12] = '{1,0,0,0,0,1,7,2,0,0,0, 0,0,0,0,0,0,0,0};  // LW x7
        tbl[13] = '{1,1,7,0,0,1,8,1,0,1,0, 0,1,1,0,0,1,0,0};  // squash over stall
        tbl[14] = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        tbl[15] = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,7};
        tbl[16] = '{1,0,0,0,0,1,9,1,0,0,0, 0,0,0,0,0,0,0,0};  // x9 (older)
        tbl[17] = '{1,0,0,1,9,1,9,1,0,0,0, 0,0,0,0,1,1,0,0};  // x9 (younger)
        tbl[18] = '{1,1,9,0,0,0,0,1,0,0,0, 0,0,0,1,0,1,0,0};  // youngest wins

        model_clear();
        rst = 1'b1;
        drive(0,0,0,0,0,0,0,0,0,0,0);
        #1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_model("reset");
        chk("reset_valX_const", val_X, 0);
        chk("reset_rfwen_const", rf_wen_W, 0);
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].val, tbl[i].r1e, tbl[i].r1, tbl[i].r2e, tbl[i].r2, tbl[i].wen,
                  tbl[i].rd, tbl[i].rdy, tbl[i].jmp, tbl[i].rx, tbl[i].fz);
            @(negedge clk);
            chk($sformatf("v%0d_stallD", i), stall_D, tbl[i].stall);
            chk($sformatf("v%0d_stallF", i), stall_F, tbl[i].stall);
            chk($sformatf("v%0d_sqF", i), squash_F, tbl[i].sqF);
            chk($sformatf("v%0d_sqD", i), squash_D, tbl[i].sqD);
            chk($sformatf("v%0d_sel1", i), op1_sel, tbl[i].s1);
            chk($sformatf("v%0d_sel2", i), op2_sel, tbl[i].s2);
            chk($sformatf("v%0d_valX", i), val_X, tbl[i].valx);
            chk($sformatf("v%0d_rfwen", i), rf_wen_W, tbl[i].rfw);
            chk($sformatf("v%0d_waddr", i), rf_waddr_W, tbl[i].wa);
            tick();
        end

        // freeze: X holds x10, W holds x9; three frozen cycles with a pending redirect
        drive(1,0,0,0,0,1,10,1,0,0,0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1,1,10,0,0,1,11,1,1,1,1);
            @(negedge clk);
            chk($sformatf("frz%0d_rfwen", c), rf_wen_W, 0);
            chk($sformatf("frz%0d_stallD", c), stall_D, 1);
            chk($sformatf("frz%0d_stallF", c), stall_F, 1);
            chk($sformatf("frz%0d_sqD", c), squash_D, 0);
            chk($sformatf("frz%0d_sqF", c), squash_F, 0);
            chk($sformatf("frz%0d_valX", c), val_X, 1);
            chk($sformatf("frz%0d_waddr", c), rf_waddr_W, 9);
            tick();
        end
        drive(1,1,10,0,0,1,11,1,0,1,0);
        @(negedge clk);
        chk("unfrz_rfwen", rf_wen_W, 1);
        chk("unfrz_waddr", rf_waddr_W, 9);
        chk("unfrz_sqD", squash_D, 1);
        chk("unfrz_stallD", stall_D, 0);
        tick();

        // reset mid-stream with freeze also high: rst wins
        for (int c = 1; c <= 3; c++) begin
            drive(1,0,0,0,0,1,c,1,0,0,0);
            tick();
        end
        rst = 1'b1;
        drive(1,1,2,1,3,1,4,1,0,0,1);
        tick();
        rst = 1'b0;
        drive(1,1,2,1,3,1,4,1,0,0,0);
        @(negedge clk);
        chk("rst_valX", val_X, 0);
        chk("rst_rfwen", rf_wen_W, 0);
        chk("rst_waddr", rf_waddr_W, 0);
        chk("rst_sel1", op1_sel, 0);
        chk("rst_sel2", op2_sel, 0);
        chk("rst_stallD", stall_D, 0);
        chk("rst_stallF", stall_F, 0);
        chk("rst_sqD", squash_D, 0);
        chk("rst_sqF", squash_F, 0);
        chk("rst5_valX", val_X5, 0);
        chk("rst5_rfwen", rf_wen_W5, 0);
        tick();

        // 5-stage pipeline, producer ready at stage 4: three stall cycles then sel=4
        drive(1,0,0,0,0,1,13,4,0,0,0);
        rdy_D = 2'd2;
        tick();
        drive(1,1,13,0,0,1,14,1,0,0,0);
        stalls = 0;
        sel_after = 0;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (stall_D5) stalls++;
            else begin
                done = 1;
                sel_after = int'(op1_sel5);
            end
            tick();
        end
        chk("n5_resolved_in_bound", done, 1);
        chk("n5_stall_cycles", stalls, 3);
        chk("n5_sel", sel_after, 4);

        // randomized comparison against the model
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            val_D      = ($urandom_range(0, 3) != 0);
            rs1_en_D   = $urandom_range(0, 1);
            rs2_en_D   = $urandom_range(0, 1);
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            wen_D      = ($urandom_range(0, 3) != 0);
            rd_D       = 5'($urandom_range(0, 3));
            rdy_D      = 2'($urandom_range(1, 3));
            rdy5_D     = 3'($urandom_range(1, 5));
            jump_D     = ($urandom_range(0, 7) == 0);
            redirect_X = ($urandom_range(0, 7) == 0);
            freeze     = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
